// File: rtl/seq_ctrl_bench_pkg.sv
// -----------------------------------------------------------------------------
// seq_bench_pkg
// Shared types and helpers for the seq_ctrl_bench controller.
//   state_t      : controller FSM encoding (IDLE/LOAD/RUN/DONE)
//   lfsr_step    : one shift of the W-bit datapath LFSR, W passed at call time
//   CH_* / chain_len : scan-chain ordering (state first, nearest SI)
// Optional feature macro used by the top: SCAN_CHAIN_EN.
// -----------------------------------------------------------------------------
package seq_bench_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Widest datapath lfsr_step can handle; the top zero-extends into it.
    localparam int LFSR_MAX_W = 64;

    // Scan chain order is SI->state->PTR->cnt->acc->DATA_OUT->GNT->SO.
    // Fields further along the chain start at offsets derived from the
    // parameter-dependent widths, so only the fixed head is pinned here.
    localparam int CH_STATE_LSB = 0;
    localparam int CH_STATE_W   = 2;
    localparam int CH_PTR_LSB   = CH_STATE_LSB + CH_STATE_W;

    function automatic int chain_len(input int pw, input int cnt_w, input int w, input int n_ch);
        return CH_STATE_W + pw + cnt_w + 2 * w + n_ch;
    endfunction

    // acc <= {acc[w-2:0], acc[w-1] ^ acc[w-2]}, computed on a wide vector and
    // masked back to w bits so one function serves every datapath width.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_step(input logic [LFSR_MAX_W-1:0] v,
                                                        input int unsigned             w);
        logic [LFSR_MAX_W-1:0] top2;
        logic [LFSR_MAX_W-1:0] mask;
        logic [LFSR_MAX_W-1:0] r;
        top2 = v >> (w - 2);
        mask = (w >= LFSR_MAX_W) ? '1 : ((LFSR_MAX_W'(1) << w) - LFSR_MAX_W'(1));
        r    = ((v << 1) | {{(LFSR_MAX_W-1){1'b0}}, top2[1] ^ top2[0]}) & mask;
        return r;
    endfunction

endpackage

// File: rtl/seq_ctrl_bench_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker.
//   req  [N_CH-1:0] : request vector
//   ptr  [PW-1:0]   : highest-priority channel this round
//   pick [N_CH-1:0] : one-hot winner (first set bit scanning ptr, ptr+1, ...)
//   any             : at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N_CH = 4,
    parameter int PW   = 2
) (
    input  logic [N_CH-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [N_CH-1:0] pick,
    output logic            any
);

    int              s;
    logic [N_CH-1:0] rot;
    logic [N_CH-1:0] low;

    always_comb begin
        // A pointer outside 0..N_CH-1 can only appear after a scan load;
        // treat it as channel 0 so the pick stays one-hot.
        s    = (int'(ptr) >= N_CH) ? 0 : int'(ptr);
        // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
        rot  = (req >> s) | (req << (N_CH - s));
        low  = rot & (~rot + N_CH'(1));
        pick = (low << s) | (low >> (N_CH - s));
        any  = |req;
    end

endmodule

// File: rtl/seq_ctrl_bench.sv
// -----------------------------------------------------------------------------
// seq_ctrl_bench
// N_CH requesters share one W-bit LFSR datapath. A round-robin winner is
// granted, its seed is loaded, the LFSR runs RUN_LEN steps and the result is
// strobed out with a per-channel completion pulse.
//
// Ports
//   CK, RST      clock (rising), synchronous active-high reset
//   REQ          per-channel level request, held until its DONE_P
//   LOAD_VAL     per-channel seeds, channel i at [i*W +: W]
//   HOLD         global stall (freezes state/acc/cnt/PTR, masks strobes)
//   GNT          registered one-hot grant
//   BUSY         high in LOAD/RUN/DONE
//   DATA_OUT     last result, held until the next completed job
//   DATA_VLD     1-cycle result strobe
//   DONE_P       1-cycle completion pulse on the granted channel bit
//   ERR          1-cycle abort pulse (granted request dropped mid-job)
//   SE, SI, SO   scan enable / in / out, present only with SCAN_CHAIN_EN
//
// Optional feature: define SCAN_CHAIN_EN to add the scan chain. Without it
// the block behaves exactly as with SE tied low.
// -----------------------------------------------------------------------------
module seq_ctrl_bench
    import seq_bench_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int W       = 8,
    parameter int RUN_LEN = 5
) (
    input  logic              CK,
    input  logic              RST,
    input  logic [N_CH-1:0]   REQ,
    input  logic [N_CH*W-1:0] LOAD_VAL,
    input  logic              HOLD,
`ifdef SCAN_CHAIN_EN
    input  logic              SE,
    input  logic              SI,
    output logic              SO,
`endif
    output logic [N_CH-1:0]   GNT,
    output logic              BUSY,
    output logic [W-1:0]      DATA_OUT,
    output logic              DATA_VLD,
    output logic [N_CH-1:0]   DONE_P,
    output logic              ERR
);

    localparam int CNT_W = $clog2(RUN_LEN) + 1;
    localparam int PW    = $clog2(N_CH);

    state_t           st;
    logic [PW-1:0]    ptr;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     acc;

    logic [N_CH-1:0]  pick;
    logic             any_req;
    logic [PW-1:0]    gidx;
    logic [PW-1:0]    ptr_nxt;
    logic [W-1:0]     seed;
    logic [W-1:0]     acc_nxt;
    logic             req_ok;

    rr_pick #(
        .N_CH (N_CH),
        .PW   (PW)
    ) u_pick (
        .req  (REQ),
        .ptr  (ptr),
        .pick (pick),
        .any  (any_req)
    );

    // Granted-channel decode: index, its seed, whether it still requests,
    // and the pointer to use once this job ends (done or aborted).
    always_comb begin
        gidx = '0;
        seed = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (GNT[i]) begin
                gidx = PW'(i);
                seed = seed | LOAD_VAL[i*W +: W];
            end
        end
        req_ok  = |(REQ & GNT);
        ptr_nxt = (gidx == PW'(N_CH - 1)) ? '0 : gidx + PW'(1);
        acc_nxt = W'(lfsr_step(LFSR_MAX_W'(acc), W));
    end

    assign BUSY = (st != IDLE);

`ifdef SCAN_CHAIN_EN
    localparam int CH_LEN      = chain_len(PW, CNT_W, W, N_CH);
    localparam int CH_CNT_LSB  = CH_PTR_LSB + PW;
    localparam int CH_ACC_LSB  = CH_CNT_LSB + CNT_W;
    localparam int CH_DOUT_LSB = CH_ACC_LSB + W;
    localparam int CH_GNT_LSB  = CH_DOUT_LSB + W;

    // Bit 0 is the flop nearest SI; each shift moves every bit one step up.
    logic [CH_LEN-1:0] chain;
    logic [CH_LEN-1:0] chain_sh;

    assign chain    = {GNT, DATA_OUT, acc, cnt, ptr, st};
    assign chain_sh = {chain[CH_LEN-2:0], SI};
    assign SO       = chain[CH_LEN-1];
`endif

    always_ff @(posedge CK) begin
        if (RST) begin
            st       <= IDLE;
            ptr      <= '0;
            cnt      <= '0;
            acc      <= '0;
            GNT      <= '0;
            DATA_OUT <= '0;
            DATA_VLD <= 1'b0;
            DONE_P   <= '0;
            ERR      <= 1'b0;
        end
`ifdef SCAN_CHAIN_EN
        else if (SE) begin
            st       <= state_t'(chain_sh[CH_STATE_LSB +: CH_STATE_W]);
            ptr      <= chain_sh[CH_PTR_LSB  +: PW];
            cnt      <= chain_sh[CH_CNT_LSB  +: CNT_W];
            acc      <= chain_sh[CH_ACC_LSB  +: W];
            DATA_OUT <= chain_sh[CH_DOUT_LSB +: W];
            GNT      <= chain_sh[CH_GNT_LSB  +: N_CH];
            DATA_VLD <= 1'b0;
            DONE_P   <= '0;
            ERR      <= 1'b0;
        end
`endif
        else begin
            DATA_VLD <= 1'b0;
            DONE_P   <= '0;
            ERR      <= 1'b0;
            case (st)
                IDLE: begin
                    if (!HOLD && any_req) begin
                        GNT <= pick;
                        st  <= LOAD;
                    end
                end
                LOAD, RUN: begin
                    if (!req_ok) begin
                        // Abort wins over HOLD for the state change; the
                        // ERR strobe itself stays masked while stalled.
                        st  <= IDLE;
                        GNT <= '0;
                        ptr <= ptr_nxt;
                        ERR <= !HOLD;
                    end else if (!HOLD) begin
                        if (st == LOAD) begin
                            acc <= seed;
                            cnt <= CNT_W'(RUN_LEN - 1);
                            st  <= RUN;
                        end else begin
                            // Step on every RUN cycle including cnt==0,
                            // giving exactly RUN_LEN steps.
                            acc <= acc_nxt;
                            if (cnt == '0) st <= DONE;
                            else           cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (!HOLD) begin
                        DATA_OUT <= acc;
                        DATA_VLD <= 1'b1;
                        DONE_P   <= GNT;
                        GNT      <= '0;
                        ptr      <= ptr_nxt;
                        st       <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_ctrl_bench.sv
module tb_seq_ctrl_bench;

    localparam int N_CH    = 4;
    localparam int W       = 8;
    localparam int RUN_LEN = 5;

    logic              CK = 1'b0;
    logic              RST;
    logic [N_CH-1:0]   REQ;
    logic [N_CH*W-1:0] LOAD_VAL;
    logic              HOLD;
    logic [N_CH-1:0]   GNT;
    logic              BUSY;
    logic [W-1:0]      DATA_OUT;
    logic              DATA_VLD;
    logic [N_CH-1:0]   DONE_P;
    logic              ERR;
`ifdef SCAN_CHAIN_EN
    logic              SE;
    logic              SI;
    logic              SO;
`endif

    always #5 CK = ~CK;

    seq_ctrl_bench #(.N_CH(N_CH), .W(W), .RUN_LEN(RUN_LEN)) dut (
        .CK       (CK),
        .RST      (RST),
        .REQ      (REQ),
        .LOAD_VAL (LOAD_VAL),
        .HOLD     (HOLD),
`ifdef SCAN_CHAIN_EN
        .SE       (SE),
        .SI       (SI),
        .SO       (SO),
`endif
        .GNT      (GNT),
        .BUSY     (BUSY),
        .DATA_OUT (DATA_OUT),
        .DATA_VLD (DATA_VLD),
        .DONE_P   (DONE_P),
        .ERR      (ERR)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model (job-level) ----------------
    // A job is tracked by its age in productive (non-held) cycles since the
    // grant: age 0 is the load cycle, 1..RUN_LEN are datapath steps, and
    // RUN_LEN+1 is the completion cycle. The result is computed in one go
    // from the seed seen at the load cycle.
    bit              m_busy = 0;
    int              m_age  = 0;
    int              m_ch   = 0;
    int              m_ptr  = 0;
    int unsigned     m_res  = 0;
    logic [N_CH-1:0] m_gnt  = '0;
    logic [W-1:0]    m_dout = '0;
    bit              m_vld  = 0;
    logic [N_CH-1:0] m_donep = '0;
    bit              m_err  = 0;

    function automatic int unsigned ref_run(input int unsigned seed);
        int unsigned v;
        int unsigned fb;
        v = seed;
        for (int k = 0; k < RUN_LEN; k++) begin
            fb = ((v >> (W - 1)) ^ (v >> (W - 2))) & 1;
            v  = ((v << 1) | fb) & ((1 << W) - 1);
        end
        return v;
    endfunction

    task automatic model_edge();
        bit found;
        int c;
        m_vld   = 0;
        m_donep = '0;
        m_err   = 0;
        if (RST) begin
            m_busy = 0; m_age = 0; m_ptr = 0; m_gnt = '0; m_dout = '0;
        end else if (!m_busy) begin
            if (!HOLD && REQ != '0) begin
                found = 0;
                for (int k = 0; k < N_CH; k++) begin
                    c = (m_ptr + k) % N_CH;
                    if (!found && REQ[c]) begin
                        m_ch  = c;
                        found = 1;
                    end
                end
                m_gnt  = '0;
                m_gnt[m_ch] = 1'b1;
                m_busy = 1;
                m_age  = 0;
            end
        end else if (m_age <= RUN_LEN && !REQ[m_ch]) begin
            m_busy = 0;
            m_gnt  = '0;
            m_ptr  = (m_ch + 1) % N_CH;
            m_err  = !HOLD;
        end else if (!HOLD) begin
            if (m_age == RUN_LEN + 1) begin
                m_dout  = W'(m_res);
                m_vld   = 1;
                m_donep = m_gnt;
                m_gnt   = '0;
                m_ptr   = (m_ch + 1) % N_CH;
                m_busy  = 0;
            end else begin
                if (m_age == 0) m_res = ref_run(32'(LOAD_VAL[m_ch*W +: W]));
                m_age++;
            end
        end
    endtask

    task automatic compare_all();
        chk("gnt",      32'(GNT),      32'(m_gnt));
        chk("busy",     32'(BUSY),     32'(m_busy));
        chk("data_out", 32'(DATA_OUT), 32'(m_dout));
        chk("data_vld", 32'(DATA_VLD), 32'(m_vld));
        chk("done_p",   32'(DONE_P),   32'(m_donep));
        chk("err",      32'(ERR),      32'(m_err));
    endtask

    task automatic tick();
        @(posedge CK);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        REQ = '0;
        HOLD = 1'b0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got %0d checks expected completion", n_chk);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int got;
        logic [N_CH-1:0] exp_seq [5];
        RST = 1'b1;
        REQ = '0;
        HOLD = 1'b0;
        LOAD_VAL = '0;
`ifdef SCAN_CHAIN_EN
        SE = 1'b0;
        SI = 1'b0;
`endif

        // Reset for two cycles: every output zero on each.
        tick();
        chk("rst1_gnt", 32'(GNT), 32'h0);
        tick();
        chk("rst2_gnt", 32'(GNT), 32'h0);
        chk("rst2_busy", 32'(BUSY), 32'h0);
        RST = 1'b0;

        // Single job, seed 0x81 on channel 0 -> 0x30 after 8 edges.
        LOAD_VAL = {W'($urandom), W'($urandom), W'($urandom), 8'h81};
        REQ = 4'b0001;
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (n == 1) chk("single_gnt", 32'(GNT), 32'h1);
            if (DATA_VLD) break;
        end
        chk("single_latency", 32'(n), 32'd8);
        chk("single_result", 32'(DATA_OUT), 32'h30);
        chk("single_donep", 32'(DONE_P), 32'h1);
        REQ = '0;
        tick();
        chk("single_hold_dout", 32'(DATA_OUT), 32'h30);

        // All channels requesting from PTR=0: completions 0,1,2,3,0.
        do_reset();
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < N_CH; i++) LOAD_VAL[i*W +: W] = W'($urandom);
        REQ = 4'b1111;
        got = 0;
        n = 0;
        while (got < 5 && n < 100) begin
            tick();
            n++;
            if (DONE_P != '0) begin
                chk("rr_order", 32'(DONE_P), 32'(exp_seq[got]));
                got++;
            end
        end
        chk("rr_count", 32'(got), 32'd5);
        REQ = '0;
        tick();
        tick();

        // Channel 2 drops its request in the second RUN cycle.
        do_reset();
        REQ = 4'b0100;
        tick();
        chk("abort_gnt", 32'(GNT), 32'h4);
        tick();   // LOAD -> RUN
        tick();   // first RUN cycle
        REQ = 4'b0000;
        tick();
        chk("abort_err", 32'(ERR), 32'h1);
        chk("abort_vld", 32'(DATA_VLD), 32'h0);
        chk("abort_gnt0", 32'(GNT), 32'h0);
        REQ = 4'b1001;
        tick();
        chk("abort_next", 32'(GNT), 32'h8);
        n = 0;
        while (n < 20 && !DATA_VLD) begin
            tick();
            n++;
        end
        chk("abort_next_done", 32'(DONE_P), 32'h8);
        REQ = '0;
        tick();

        // HOLD for 3 cycles mid-RUN delays the result by exactly 3 cycles.
        do_reset();
        LOAD_VAL[0 +: W] = 8'h81;
        REQ = 4'b0001;
        n = 0;
        while (n < 25) begin
            HOLD = (n >= 4 && n <= 6);
            tick();
            n++;
            if (n >= 5 && n <= 7) begin
                chk("hold_no_vld", 32'(DATA_VLD), 32'h0);
                chk("hold_no_donep", 32'(DONE_P), 32'h0);
            end
            if (DATA_VLD) break;
        end
        HOLD = 1'b0;
        chk("hold_latency", 32'(n), 32'd11);
        chk("hold_result", 32'(DATA_OUT), 32'h30);
        REQ = '0;
        tick();

        // Randomized traffic with aborts, stalls, zero seeds and resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            RST  = ($urandom_range(299, 0) == 0);
            HOLD = ($urandom_range(7, 0) == 0);
            for (int i = 0; i < N_CH; i++) begin
                if (REQ[i]) begin
                    if ((DONE_P[i] && $urandom_range(1, 0) == 1) || $urandom_range(40, 0) == 0)
                        REQ[i] = 1'b0;
                end else if ($urandom_range(3, 0) == 0) begin
                    REQ[i] = 1'b1;
                end
            end
            n = $urandom_range(N_CH - 1, 0);
            LOAD_VAL[n*W +: W] = ($urandom_range(9, 0) == 0) ? '0 : W'($urandom);
            tick();
        end
        RST = 1'b0;
        HOLD = 1'b0;
        REQ = '0;
        tick();

`ifdef SCAN_CHAIN_EN
        begin
            localparam int L = 2 + $clog2(N_CH) + ($clog2(RUN_LEN) + 1) + 2 * W + N_CH;
            logic [L-1:0] pat;
            for (int k = 0; k < L; k++) pat[k] = 1'($urandom);
            SE = 1'b1;
            for (int k = 0; k < L; k++) begin
                SI = pat[k];
                @(posedge CK);
                #1;
                chk("scan_no_vld", 32'(DATA_VLD), 32'h0);
            end
            for (int k = 0; k < L; k++) begin
                chk("scan_so", 32'(SO), 32'(pat[k]));
                SI = 1'b0;
                @(posedge CK);
                #1;
            end
            SI = 1'b1;
            for (int k = 0; k < 5; k++) begin
                @(posedge CK);
                #1;
            end
            RST = 1'b1;
            @(posedge CK);
            #1;
            chk("scan_rst_so", 32'(SO), 32'h0);
            chk("scan_rst_gnt", 32'(GNT), 32'h0);
            chk("scan_rst_dout", 32'(DATA_OUT), 32'h0);
            chk("scan_rst_busy", 32'(BUSY), 32'h0);
            RST = 1'b0;
            SI = 1'b0;
            for (int k = 0; k < L; k++) begin
                @(posedge CK);
                #1;
                chk("scan_zero_so", 32'(SO), 32'h0);
            end
            SE = 1'b0;
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
